// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl
// Bit-serial adder/subtractor. A single full-adder cell, built from two
// half adders and an OR, is stepped over a WIDTH-bit operand pair LSB
// first, one bit per clock. Subtraction is A + ~B + 1: B is inverted at
// capture and the carry register is seeded with 1.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for START; READY=1
// S_RUN  | one operand bit per cycle, WIDTH cycles total
// S_DONE | one-cycle DONE pulse; RESULT/CARRY/OVERFLOW now valid
module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic             OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             OVERFLOW
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry_reg;
    logic             cin_msb;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;

    logic ha1_s;
    logic ha1_c;
    logic ha2_s;
    logic ha2_c;
    logic cell_s;
    logic cell_c;

    // Full-adder cell: two half-adder stages plus an OR for the carry.
    always_comb begin
        ha1_s    = opa[0] ^ opb[0];
        ha1_c    = opa[0] & opb[0];
        ha2_s    = ha1_s ^ carry_reg;
        ha2_c    = ha1_s & carry_reg;
        cell_s   = ha2_s;
        cell_c   = ha1_c | ha2_c;
        res_next = {cell_s, res_sr[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; START outside IDLE is simply not looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, serial shift, carry chain and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa       <= '0;
            opb       <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            carry_reg <= 1'b0;
            cin_msb   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        opa       <= A;
                        opb       <= OP ? ~B : B;
                        carry_reg <= OP;
                        cnt       <= '0;
                        cin_msb   <= 1'b0;
                    end
                end
                S_RUN: begin
                    opa       <= opa >> 1;
                    opb       <= opb >> 1;
                    res_sr    <= res_next;
                    carry_reg <= cell_c;
                    // The carry leaving bit WIDTH-2 is the carry into the MSB.
                    if (cnt == CNT_PRE) begin
                        cin_msb <= cell_c;
                    end
                    // Hold at the last count rather than wrap.
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers load only on the edge that enters DONE, so partial
    // sums never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (state == S_RUN && cnt == CNT_LAST) begin
            result_q <= res_next;
            carry_q  <= cell_c;
            ovf_q    <= cin_msb ^ cell_c;
        end
    end

    // Handshake outputs decode straight from the state register so that an
    // asynchronous reset is reflected immediately.
    always_comb begin
        READY    = (state == S_IDLE);
        BUSY     = (state == S_RUN) || (state == S_DONE);
        DONE     = (state == S_DONE);
        RESULT   = result_q;
        CARRY    = carry_q;
        OVERFLOW = ovf_q;
    end

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Bench for serial_add_sub_ctrl: expected results are queued when an
// operation is launched and compared when DONE pulses.
module tb_serial_add_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         START = 1'b0;
    logic         OP = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         READY;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic         CARRY;
    logic         OVERFLOW;

    serial_add_sub_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .START    (START),
        .OP       (OP),
        .A        (A),
        .B        (B),
        .READY    (READY),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT),
        .CARRY    (CARRY),
        .OVERFLOW (OVERFLOW)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    // {overflow, carry, result}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_e;
    logic [W+1:0] last_out = '0;

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic op);
        logic [W:0] s;
        logic       v;
        if (op) begin
            s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {v, s};
    endfunction

    // Scoreboard: pop on DONE, otherwise outputs must hold the last result.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_out = '0;
        end else if (DONE) begin
            done_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got DONE with RESULT=%h CARRY=%b OVERFLOW=%b, required no DONE",
                         RESULT, CARRY, OVERFLOW);
                last_out = {OVERFLOW, CARRY, RESULT};
            end else begin
                mon_e = exp_q.pop_front();
                if ({OVERFLOW, CARRY, RESULT} !== mon_e) begin
                    n_err++;
                    $display("FAIL result: got ov/c/res=%b/%b/%h required %b/%b/%h",
                             OVERFLOW, CARRY, RESULT, mon_e[W+1], mon_e[W], mon_e[W-1:0]);
                end
                last_out = mon_e;
            end
        end else begin
            n_cmp++;
            if ({OVERFLOW, CARRY, RESULT} !== last_out) begin
                n_err++;
                $display("FAIL hold: got ov/c/res=%b/%b/%h required %b/%b/%h",
                         OVERFLOW, CARRY, RESULT, last_out[W+1], last_out[W], last_out[W-1:0]);
                last_out = {OVERFLOW, CARRY, RESULT};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int t;
        t = 0;
        @(negedge clk);
        while (!READY && t < 4 * W) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (READY !== 1'b1) begin
            n_err++;
            $display("FAIL ready_timeout: READY=%b required 1", READY);
        end
        A = a;
        B = b;
        OP = op;
        START = 1'b1;
        exp_q.push_back(model(a, b, op));
        @(posedge clk);
        #1 START = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int lat;
        start_op(a, b, op);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!DONE && lat < 4 * W);
        n_cmp++;
        if (lat != W + 1) begin
            n_err++;
            $display("FAIL latency: got %0d cycles required %0d", lat, W + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({READY, BUSY, DONE} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_handshake: READY/BUSY/DONE=%b required 100", {READY, BUSY, DONE});
        end
        n_cmp++;
        if ({OVERFLOW, CARRY, RESULT} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ov/c/res=%b/%b/%h required 0/0/00", OVERFLOW, CARRY, RESULT);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_add_basic();
        int lat;
        int busy;
        start_op(8'h3C, 8'h05, 1'b0);
        lat = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!READY) busy++;
        end while (!DONE && lat < 4 * W);
        n_cmp++;
        if (lat != W + 1) begin
            n_err++;
            $display("FAIL add_latency: got %0d required %0d", lat, W + 1);
        end
        @(negedge clk);
        n_cmp++;
        if (DONE !== 1'b0 || READY !== 1'b1) begin
            n_err++;
            $display("FAIL done_width: DONE=%b READY=%b required 0 1", DONE, READY);
        end
        n_cmp++;
        if (busy != W + 1) begin
            n_err++;
            $display("FAIL ready_low: got %0d cycles required %0d", busy, W + 1);
        end
    endtask

    task automatic test_boundaries();
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'h05, 8'h07, 1'b1);
        run_op(8'h80, 8'h01, 1'b1);
        run_op(8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_mid_run();
        int d0;
        int t;
        start_op(8'h10, 8'h20, 1'b0);
        d0 = done_seen;
        repeat (2) @(posedge clk);
        #1;
        A = 8'hFF;
        B = 8'hFF;
        OP = 1'b1;
        START = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!DONE && t < 4 * W);
        START = 1'b0;
        repeat (W + 4) @(negedge clk);
        n_cmp++;
        if (done_seen - d0 != 1) begin
            n_err++;
            $display("FAIL mid_run_done_count: got %0d required 1", done_seen - d0);
        end
        n_cmp++;
        if (READY !== 1'b1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_run_idle: READY=%b pending=%0d required 1 0", READY, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        start_op(8'h55, 8'h11, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({READY, BUSY, DONE} !== 3'b100) begin
            n_err++;
            $display("FAIL async_reset_handshake: READY/BUSY/DONE=%b required 100", {READY, BUSY, DONE});
        end
        n_cmp++;
        if ({OVERFLOW, CARRY, RESULT} !== '0) begin
            n_err++;
            $display("FAIL async_reset_outputs: ov/c/res=%b/%b/%h required 0/0/00", OVERFLOW, CARRY, RESULT);
        end
        exp_q.delete();
        last_out = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        d0 = done_seen;
        repeat (W + 4) @(negedge clk);
        n_cmp++;
        if (done_seen != d0) begin
            n_err++;
            $display("FAIL reset_abort: got %0d DONE pulses required 0", done_seen - d0);
        end
        run_op(8'h01, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back();
        int pulses;
        int last_done;
        int t;
        pulses = 0;
        last_done = -1;
        t = 0;
        @(negedge clk);
        while (!READY && t < 4 * W) begin
            @(negedge clk);
            t++;
        end
        A = 8'h01;
        B = 8'h01;
        OP = 1'b0;
        START = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (READY) exp_q.push_back(model(8'h01, 8'h01, 1'b0));
            if (DONE) begin
                if (last_done >= 0) begin
                    n_cmp++;
                    if (i - last_done != W + 2) begin
                        n_err++;
                        $display("FAIL b2b_spacing: got %0d cycles required %0d", i - last_done, W + 2);
                    end
                end
                last_done = i;
                pulses++;
            end
            @(negedge clk);
        end
        START = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 4 * W) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: %0d operations pending required 0", exp_q.size());
        end
        n_cmp++;
        if (pulses != 4) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d required 4", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_boundaries();
        test_random();
        test_mid_run();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
